// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder slice plus a carry flip-flop, consuming the
// operands LSB-first over WIDTH clocks and holding {cout,sum} until taken.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       o_dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in HOLD, so an
  // operation never overlaps the next one.

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic             r_cout;
  logic             r_in_ready;
  logic             r_out_valid;

  logic             w_s;
  logic             w_maj;
  logic [WIDTH-1:0] w_res_next;

  assign w_s   = r_sh_a[0] ^ r_sh_b[0] ^ r_carry;
  assign w_maj = (r_sh_a[0] & r_sh_b[0]) | (r_sh_a[0] & r_carry) | (r_sh_b[0] & r_carry);
  // Shift-and-insert form rather than a concatenation so WIDTH=1 stays legal.
  assign w_res_next = (r_res >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sh_a      <= '0;
      r_sh_b      <= '0;
      r_res       <= '0;
      r_sum       <= '0;
      r_cnt       <= '0;
      r_carry     <= 1'b0;
      r_cout      <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_sh_a     <= a;
            r_sh_b     <= b;
            r_carry    <= cin;
            r_cnt      <= '0;
            r_res      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= S_ADD;
          end
        end
        S_ADD: begin
          r_sh_a  <= r_sh_a >> 1;
          r_sh_b  <= r_sh_b >> 1;
          r_carry <= w_maj;
          r_res   <= w_res_next;
          r_cnt   <= r_cnt + 1'b1;
          if (r_cnt == LAST_CNT) begin
            r_sum       <= w_res_next;
            r_cout      <= w_maj;
            r_out_valid <= 1'b1;
            r_state     <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign sum         = r_sum;
  assign cout        = r_cout;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random checks of serial_adder at WIDTH=8, plus a WIDTH=1
// instance exercised over the full-adder truth table.
module tb_serial_adder;

  logic       clk;
  logic       rst;

  logic       in_valid8, in_ready8, cin8, out_valid8, out_ready8, cout8;
  logic [7:0] a8, b8, sum8;
  logic [1:0] dbg8;

  logic       in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1;
  logic [0:0] a1, b1, sum1;
  logic [1:0] dbg1;

  int n_checks;
  int n_errors;
  logic [8:0] exp_q[$];

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .a(a8), .b(b8), .cin(cin8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .o_dbg_state(dbg8)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .o_dbg_state(dbg1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the acceptance
  // edge, with the operand inputs scrambled to prove they were captured.
  task automatic start_op8(input string tag, input logic [7:0] a_i, input logic [7:0] b_i,
                           input logic c_i);
    check({tag, "_in_ready"}, {31'd0, in_ready8}, 32'd1);
    a8 = a_i; b8 = b_i; cin8 = c_i; in_valid8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    a8 = ~a_i; b8 = ~b_i; cin8 = ~c_i;
  endtask

  task automatic wait_result8(input string tag);
    int lat;
    lat = 0;
    while (!out_valid8 && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, 32'd8);
  endtask

  task automatic release8(input string tag);
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
    check({tag, "_rel_valid"}, {31'd0, out_valid8}, 32'd0);
    check({tag, "_rel_ready"}, {31'd0, in_ready8}, 32'd1);
  endtask

  task automatic op8(input string tag, input logic [7:0] a_i, input logic [7:0] b_i,
                     input logic c_i, input logic [7:0] exp_s, input logic exp_c);
    start_op8(tag, a_i, b_i, c_i);
    wait_result8(tag);
    check({tag, "_sum"}, {24'd0, sum8}, {24'd0, exp_s});
    check({tag, "_cout"}, {31'd0, cout8}, {31'd0, exp_c});
    release8(tag);
  endtask

  task automatic op1(input string tag, input logic a_i, input logic b_i, input logic c_i,
                     input logic exp_s, input logic exp_c);
    int lat;
    check({tag, "_in_ready"}, {31'd0, in_ready1}, 32'd1);
    a1 = a_i; b1 = b_i; cin1 = c_i; in_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid1 = 1'b0;
    a1 = ~a_i; b1 = ~b_i; cin1 = ~c_i;
    lat = 0;
    while (!out_valid1 && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, 32'd1);
    check({tag, "_sum"}, {31'd0, sum1}, {31'd0, exp_s});
    check({tag, "_cout"}, {31'd0, cout1}, {31'd0, exp_c});
    out_ready1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready1 = 1'b0;
  endtask

  initial begin
    logic [7:0] fa_sum_tbl;
    logic [7:0] fa_cout_tbl;
    logic [7:0] held_sum;
    logic       held_cout;
    logic [8:0] exp_v;
    logic [7:0] ra, rb;
    logic       rc;

    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    in_valid8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; out_ready8 = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready8}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid8}, 32'd0);
    check("rst_sum", {24'd0, sum8}, 32'd0);
    check("rst_cout", {31'd0, cout8}, 32'd0);
    check("rst_state", {30'd0, dbg8}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // directed vectors
    op8("zero", 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
    op8("ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    op8("a5_5a", 8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1);

    // backpressure while new operands are offered
    start_op8("bp", 8'h3C, 8'h42, 1'b0);
    wait_result8("bp");
    check("bp_sum", {24'd0, sum8}, 32'h7E);
    check("bp_cout", {31'd0, cout8}, 32'd0);
    held_sum = 8'h7E;
    held_cout = 1'b0;
    a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; in_valid8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_sum", {24'd0, sum8}, {24'd0, held_sum});
      check("bp_hold_cout", {31'd0, cout8}, {31'd0, held_cout});
      check("bp_hold_in_ready", {31'd0, in_ready8}, 32'd0);
      check("bp_hold_valid", {31'd0, out_valid8}, 32'd1);
    end
    out_ready8 = 1'b1;
    check("bp_no_overlap", {31'd0, in_ready8}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
    check("bp_idle_ready", {31'd0, in_ready8}, 32'd1);
    check("bp_idle_valid", {31'd0, out_valid8}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    a8 = 8'hFF; b8 = 8'hFF;
    wait_result8("bp2");
    check("bp2_sum", {24'd0, sum8}, 32'h33);
    check("bp2_cout", {31'd0, cout8}, 32'd0);

    // held result 0x33 stays visible until the asynchronous reset clears it
    out_ready8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready8 = 1'b0;
    start_op8("mid_rst", 8'hFF, 8'hFF, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3;
    check("mid_rst_pre_sum", {24'd0, sum8}, 32'h33);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid8}, 32'd0);
    check("mid_rst_sum", {24'd0, sum8}, 32'd0);
    check("mid_rst_cout", {31'd0, cout8}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready8}, 32'd1);
    check("mid_rst_state", {30'd0, dbg8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    op8("after_rst", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

    // WIDTH=1 full-adder truth table, index = {a,b,cin}
    fa_sum_tbl  = 8'b1001_0110;
    fa_cout_tbl = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      op1($sformatf("fa_%0d", i), v[2], v[1], v[0], fa_sum_tbl[i], fa_cout_tbl[i]);
    end

    // random vectors scored against the expected queue
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rc = 1'($urandom_range(0, 1));
      exp_q.push_back({1'b0, ra} + {1'b0, rb} + {8'd0, rc});
      start_op8("rnd", ra, rb, rc);
      wait_result8("rnd");
      exp_v = exp_q.pop_front();
      check("rnd_result", {23'd0, cout8, sum8}, {23'd0, exp_v});
      out_ready8 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready8 = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Bit-serial adder that wraps a single full-adder bit-slice with a carry flip-flop and shift registers. It adds two WIDTH-bit operands LSB-first, one bit per clock. Operands arrive over a valid/ready handshake, and the result is held on a valid/ready output port. It is the sequential consumer of the full-adder cell and the area-cheap alternative to a ripple-carry adder in the arithmetic datapath.

Parameters:
WIDTH, 8, operand and sum width in bits; legal range 1..32.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operands a, b, cin are valid
in_ready  output  1  block can accept operands; high only in IDLE
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in for bit 0
out_valid  output  1  sum/cout valid; high only in HOLD
out_ready  input  1  downstream accepts the result
sum  output  WIDTH  registered sum, a+b+cin mod 2^WIDTH
cout  output  1  registered carry-out of bit WIDTH-1

Behaviour:
- Reset (rst=1, asynchronous):
  - State goes to IDLE.
  - in_ready=1, out_valid=0, sum=0, cout=0.
  - Internal shift registers, carry FF and bit counter are all cleared.
  - Deasserting rst requires no special sequencing.
- FSM states: IDLE, ADD, HOLD.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: load shA<=a, shB<=b, carry<=cin, cnt<=0, then go to ADD.
  - sum/cout keep their previous values; they are don't-care to consumers while out_valid=0.
- ADD:
  - in_ready=0, out_valid=0.
  - Per edge:
    - s = shA[0]^shB[0]^carry.
    - carry <= majority(shA[0], shB[0], carry).
    - Result register shifts right with s entering at the MSB.
    - shA and shB shift right.
    - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1:
    - Go to HOLD.
    - sum <= final shifted result.
    - cout <= carry computed on that edge.
  - Exactly WIDTH edges are spent in ADD.
- HOLD:
  - out_valid=1; sum and cout stay stable.
  - On an edge with out_ready=1, go to IDLE (out_valid falls, in_ready rises after that edge).
  - out_ready=0 holds HOLD indefinitely with no change to sum/cout.
- Latency:
  - Acceptance edge E0; out_valid is high from edge E(WIDTH) onward.
  - Minimum initiation interval is WIDTH+2 cycles, i.e. with out_ready tied high.
- Inputs and handshakes outside their states:
  - a, b, cin and in_valid are ignored outside IDLE.
  - Changes to a, b or cin after the acceptance edge do not affect the result.
  - out_ready is ignored outside HOLD.
- Overlap: no overlap between operations. in_ready is not asserted in HOLD, even when out_ready=1 on the same cycle.
- Counter: the count register is $clog2(WIDTH+1) bits wide. The WIDTH=1 case is legal: a single ADD edge, which reduces the block to a registered full adder.
- Reset mid-operation: rst during ADD or HOLD aborts the operation. The partial result is discarded and all outputs return to their reset values immediately, without waiting for a clock.
- Arithmetic: {cout,sum} == a+b+cin exactly, computed as a (WIDTH+1)-bit unsigned result.

Test Plan:
- WIDTH=8, a=0x00, b=0x00, cin=0 -> sum=0x00, cout=0; out_valid rises exactly 8 edges after acceptance.
- WIDTH=8, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1. Then a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1. Then a=0x3C, b=0x42, cin=0 -> sum=0x7E, cout=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in HOLD while in_valid=1 with new operands 0x11/0x22.
  - Required response: sum/cout unchanged; in_ready=0 throughout.
  - After out_ready=1: IDLE, the 0x11+0x22 operands are accepted, and sum=0x33.
- Operand change after acceptance:
  - Stimulus: change a and b on the cycle after the acceptance edge.
  - Required response: the result reflects the originally accepted operands only.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously during the 3rd ADD cycle.
  - Required response: out_valid=0, sum=0x00, cout=0, in_ready=1 before the next clock edge.
  - Follow-up: the next operation, 0x80+0x80 cin=0, gives sum=0x00, cout=1.
- WIDTH=1 instance, all 8 combinations of a, b, cin -> sum/cout match the full-adder truth table (e.g. 1+1+1 gives sum=1, cout=1). Plus a 1000-vector random WIDTH=8 run checked against a+b+cin.
